// File: rtl/bcd_to_bin_seq_if.sv
// Handshake bundle for the sequential BCD-to-binary converter.
// master = producer/consumer side, slave = converter side.
interface bcd_to_bin_seq_if #(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned BIN_W  = 10
);
    logic                in_valid;
    logic                in_ready;
    logic [4*DIGITS-1:0] bcd_in;
    logic                out_valid;
    logic                out_ready;
    logic [BIN_W-1:0]    bin_out;
    logic                err_out;

    modport master (
        output in_valid,
        output bcd_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  bin_out,
        input  err_out
    );

    modport slave (
        input  in_valid,
        input  bcd_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output bin_out,
        output err_out
    );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble.
// One conversion takes BIN_W shift/correct steps; illegal digits short-cut straight to DONE.
module bcd_to_bin_seq #(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned BIN_W  = 10
) (
    input  logic            clk,
    input  logic            rst,
    bcd_to_bin_seq_if.slave bus
);
    localparam int unsigned BcdW = 4 * DIGITS;
    localparam int unsigned SrW  = BcdW + BIN_W;
    localparam int unsigned CntW = $clog2(BIN_W + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(BIN_W - 1);

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    state_e           state_q, state_d;
    logic [SrW-1:0]   sr_q, sr_d;     // {bcd_field, bin_field}
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic             err_q, err_d;
    logic             in_err;
    logic [SrW-1:0]   sr_step;

    // Flag any input digit above 9.
    always_comb begin
        in_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.bcd_in[4*i +: 4] > 4'd9) begin
                in_err = 1'b1;
            end
        end
    end

    // One step: shift right, then subtract 3 from every digit that is now >= 8.
    always_comb begin
        sr_step = sr_q >> 1;
        for (int i = 0; i < DIGITS; i++) begin
            // digit >= 8 exactly when its top bit is set
            if (sr_step[BIN_W + 4*i + 3]) begin
                sr_step[BIN_W + 4*i +: 4] = sr_step[BIN_W + 4*i +: 4] - 4'd3;
            end
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d       = state_q;
        sr_d          = sr_q;
        cnt_d         = cnt_q;
        bin_d         = bin_q;
        err_d         = err_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    sr_d  = {bus.bcd_in, {BIN_W{1'b0}}};
                    cnt_d = '0;
                    err_d = in_err;
                    if (in_err) begin
                        bin_d   = '0;
                        state_d = StDone;
                    end else begin
                        state_d = StConv;
                    end
                end
            end
            StConv: begin
                sr_d  = sr_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    bin_d   = sr_step[BIN_W-1:0];
                    state_d = StDone;
                end
            end
            StDone: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset discards any in-flight result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sr_q    <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
        end
    end

    assign bus.bin_out = bin_q;
    assign bus.err_out = err_q;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: drivers push expected results, monitors pop on handshake.
module tb_bcd_to_bin_seq;
    typedef struct {
        logic [9:0] bin;
        logic       err;
        int         acc;  // cycle index of the acceptance edge
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_vec;
    int   n_fail;
    exp_t q3[$];
    exp_t q2[$];

    bcd_to_bin_seq_if #(.DIGITS(3), .BIN_W(10)) b3 ();
    bcd_to_bin_seq_if #(.DIGITS(2), .BIN_W(7))  b2 ();

    bcd_to_bin_seq #(.DIGITS(3), .BIN_W(10)) u_dut3 (.clk(clk), .rst(rst), .bus(b3.slave));
    bcd_to_bin_seq #(.DIGITS(2), .BIN_W(7))  u_dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Present a value to the 3-digit DUT and hold it until accepted.
    task automatic send3(input logic [11:0] bcd, input logic [9:0] eb, input logic ee,
                         input bit push);
        int   t;
        exp_t e;
        @(negedge clk);
        b3.bcd_in   = bcd;
        b3.in_valid = 1'b1;
        t = 0;
        while (b3.in_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            check("accept3_timeout", b3.in_ready, 1);
            b3.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        b3.in_valid = 1'b0;
        b3.bcd_in   = 12'hABC;  // scribble: later input changes must not matter
        if (push) begin
            e.bin = eb;
            e.err = ee;
            e.acc = cyc;
            q3.push_back(e);
        end
        check("in_ready3_drop", b3.in_ready, 0);
    endtask

    task automatic send2(input logic [7:0] bcd, input logic [9:0] eb, input logic ee);
        int   t;
        exp_t e;
        @(negedge clk);
        b2.bcd_in   = bcd;
        b2.in_valid = 1'b1;
        t = 0;
        while (b2.in_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            check("accept2_timeout", b2.in_ready, 1);
            b2.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        b2.in_valid = 1'b0;
        e.bin = eb;
        e.err = ee;
        e.acc = cyc;
        q2.push_back(e);
        check("in_ready2_drop", b2.in_ready, 0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q3.size() != 0 || q2.size() != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) check("drain_timeout", q3.size() + q2.size(), 0);
    endtask

    // Monitor for the 3-digit DUT.
    initial begin : mon3
        bit seen;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                seen = 1'b0;
                continue;
            end
            if (b3.out_valid === 1'b1) begin
                if (q3.size() == 0) begin
                    check("unexpected_out_valid3", b3.out_valid, 0);
                end else begin
                    if (!seen) begin
                        // error path is in DONE right after acceptance
                        check("latency3", cyc - q3[0].acc, q3[0].err ? 0 : 10);
                        seen = 1'b1;
                    end
                    check("bin_out3", b3.bin_out, q3[0].bin);
                    check("err_out3", b3.err_out, q3[0].err);
                    if (b3.out_ready === 1'b1) begin
                        void'(q3.pop_front());
                        seen = 1'b0;
                        @(posedge clk);
                        #1;
                        check("in_ready3_after_hs", b3.in_ready, 1);
                        check("out_valid3_after_hs", b3.out_valid, 0);
                    end
                end
            end
        end
    end

    // Monitor for the 2-digit DUT.
    initial begin : mon2
        bit seen;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                seen = 1'b0;
                continue;
            end
            if (b2.out_valid === 1'b1) begin
                if (q2.size() == 0) begin
                    check("unexpected_out_valid2", b2.out_valid, 0);
                end else begin
                    if (!seen) begin
                        check("latency2", cyc - q2[0].acc, q2[0].err ? 0 : 7);
                        seen = 1'b1;
                    end
                    check("bin_out2", b2.bin_out, q2[0].bin);
                    check("err_out2", b2.err_out, q2[0].err);
                    if (b2.out_ready === 1'b1) begin
                        void'(q2.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : main
        int t;
        n_vec        = 0;
        n_fail       = 0;
        rst          = 1'b1;
        b3.in_valid  = 1'b0;
        b3.bcd_in    = '0;
        b3.out_ready = 1'b1;
        b2.in_valid  = 1'b0;
        b2.bcd_in    = '0;
        b2.out_ready = 1'b1;
        #3;
        check("rst_in_ready", b3.in_ready, 1);
        check("rst_out_valid", b3.out_valid, 0);
        check("rst_bin_out", b3.bin_out, 0);
        check("rst_err_out", b3.err_out, 0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;

        // Full-scale value, then a sweep of legal inputs.
        send3(12'h999, 10'd999, 1'b0, 1'b1);
        send3(12'h000, 10'd0,   1'b0, 1'b1);
        send3(12'h001, 10'd1,   1'b0, 1'b1);
        send3(12'h009, 10'd9,   1'b0, 1'b1);
        send3(12'h010, 10'd10,  1'b0, 1'b1);
        send3(12'h255, 10'd255, 1'b0, 1'b1);
        send3(12'h500, 10'd500, 1'b0, 1'b1);
        send3(12'h998, 10'd998, 1'b0, 1'b1);
        // Illegal digits.
        send3(12'h1A3, 10'd0,   1'b1, 1'b1);
        send3(12'hF00, 10'd0,   1'b1, 1'b1);
        drain();

        // Back-pressure: result held while out_ready low; 0x456 waits for IDLE.
        @(posedge clk);
        #1;
        b3.out_ready = 1'b0;
        send3(12'h123, 10'd123, 1'b0, 1'b1);
        fork
            send3(12'h456, 10'd456, 1'b0, 1'b1);
            begin
                t = 0;
                while (b3.out_valid !== 1'b1 && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                if (t >= 50) check("hold_wait_timeout", b3.out_valid, 1);
                repeat (5) @(posedge clk);
                check("held_out_valid", b3.out_valid, 1);
                check("held_in_ready", b3.in_ready, 0);
                #1;
                b3.out_ready = 1'b1;
            end
        join
        drain();

        // Reset mid-conversion discards the result.
        send3(12'h777, 10'd0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_in_ready", b3.in_ready, 1);
        check("midrst_out_valid", b3.out_valid, 0);
        check("midrst_bin_out", b3.bin_out, 0);
        check("midrst_err_out", b3.err_out, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("no_pulse_after_rst", b3.out_valid, 0);
        end
        send3(12'h042, 10'd42, 1'b0, 1'b1);
        drain();

        // Two-digit build.
        send2(8'h99, 10'd99, 1'b0);
        send2(8'h00, 10'd0,  1'b0);
        send2(8'h42, 10'd42, 1'b0);
        send2(8'h9A, 10'd0,  1'b1);
        drain();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
